// File: rtl/instr_adder_pkg.sv
// Shared widths, LA control-bit indices and config-field offsets for the instrumented adder wrapper.
package instr_adder_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned LA_W    = 32;
  localparam int unsigned IO_W    = 38;
  localparam int unsigned CNT_W   = 29;
  localparam int unsigned FIELD_W = 5;

  localparam int unsigned CTL_LOAD_A   = 0;
  localparam int unsigned CTL_LOAD_B   = 1;
  localparam int unsigned CTL_LOAD_CFG = 2;
  localparam int unsigned CTL_RUN      = 3;
  localparam int unsigned CTL_CLR_CNT  = 4;

  localparam int unsigned CFG_RING_LSB = 0;
  localparam int unsigned CFG_S_LSB    = 5;
  localparam int unsigned CFG_EXT_LSB  = 10;
  localparam int unsigned CFG_EXT_EN   = 15;

  localparam int unsigned IO_CHAIN_BIT = 8;
  localparam int unsigned IO_EXT_BIT   = 9;

  // Bit-select field to one-hot operand mask.
  function automatic logic [WIDTH-1:0] onehot(input logic [FIELD_W-1:0] idx);
    return WIDTH'(1) << idx;
  endfunction

endpackage

// File: rtl/kogge_stone_adder.sv
// Combinational Kogge-Stone parallel-prefix adder, carry-in tied to 0.
module kogge_stone_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned STAGES = $clog2(WIDTH);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] p_nxt;

  // Each stage combines group (g,p) with the group 2^k positions below.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    p0    = p;
    g_nxt = g;
    p_nxt = p;
    for (int k = 0; k < STAGES; k++) begin
      g_nxt = g;
      p_nxt = p;
      for (int i = (1 << k); i < WIDTH; i++) begin
        g_nxt[i] = g[i] | (p[i] & g[i - (1 << k)]);
        p_nxt[i] = p[i] & p[i - (1 << k)];
      end
      g = g_nxt;
      p = p_nxt;
    end
    sum  = p0 ^ {g[WIDTH-2:0], 1'b0};
    cout = g[WIDTH-1];
  end

endmodule

// File: rtl/instrumented_adder_kogge_wrapper.sv
// Caravel-style wrapper: KS adder with ring-oscillation test mode and cycle/toggle counters.
// Optional ADDER_RIPPLE_REF_EN adds a behavioural reference sum and sticky mismatch flag.
module instrumented_adder_kogge_wrapper
  import instr_adder_pkg::*;
(
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            active,
  input  logic [LA_W-1:0] la1_data_in,
  output logic [LA_W-1:0] la1_data_out,
  input  logic [LA_W-1:0] la1_oenb,
  input  logic [LA_W-1:0] la2_data_in,
  output logic [LA_W-1:0] la2_data_out,
  input  logic [LA_W-1:0] la2_oenb,
  input  logic [LA_W-1:0] la3_data_in,
  output logic [LA_W-1:0] la3_data_out,
  input  logic [LA_W-1:0] la3_oenb,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);

  logic [WIDTH-1:0] a_input, b_input;
  logic [WIDTH-1:0] ring_mask, s_mask, ext_mask;
  logic             ext_en;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             chain_out;
  logic [CNT_W-1:0] cycle_cnt;
  logic [LA_W-1:0]  toggle_cnt;
  logic             done;
  logic             mismatch;

  logic [WIDTH-1:0] ks_sum;
  logic             ks_cout;
  logic             fb;
  logic [WIDTH-1:0] a_next;
  logic [CNT_W-1:0] cnt_next;
  logic             load_a, load_b, load_cfg, run, clr_cnt;
  logic             unused_inputs;

  assign load_a   = la1_data_in[CTL_LOAD_A];
  assign load_b   = la1_data_in[CTL_LOAD_B];
  assign load_cfg = la1_data_in[CTL_LOAD_CFG];
  assign run      = la1_data_in[CTL_RUN];
  assign clr_cnt  = la1_data_in[CTL_CLR_CNT];

  assign unused_inputs = ^{la1_data_in[LA_W-1:CTL_CLR_CNT+1], la1_oenb, la2_oenb, la3_oenb,
                           la2_data_in[LA_W-1:CFG_EXT_EN+1], io_in[IO_W-1:IO_EXT_BIT+1],
                           io_in[IO_EXT_BIT-1:0]};

  kogge_stone_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (a_input),
    .b    (b_input),
    .sum  (ks_sum),
    .cout (ks_cout)
  );

  assign fb = |(ks_sum & s_mask);

  // Ring bit takes inverted feedback; external bit overrides on the same position.
  always_comb begin
    a_next = (a_input & ~ring_mask) | (ring_mask & {WIDTH{~fb}});
    if (ext_en) begin
      a_next = (a_next & ~ext_mask) | (ext_mask & {WIDTH{io_in[IO_EXT_BIT]}});
    end
  end

  assign cnt_next = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_input    <= '0;
      b_input    <= '0;
      ring_mask  <= '0;
      s_mask     <= '0;
      ext_mask   <= '0;
      ext_en     <= 1'b0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      chain_out  <= 1'b0;
      cycle_cnt  <= '0;
      toggle_cnt <= '0;
      done       <= 1'b0;
    end else begin
      sum_q   <= ks_sum;
      carry_q <= ks_cout;
      if (!run) begin
        if (load_a) a_input <= la2_data_in;
        if (load_b) b_input <= la2_data_in;
        if (load_cfg) begin
          ring_mask <= onehot(la2_data_in[CFG_RING_LSB +: FIELD_W]);
          s_mask    <= onehot(la2_data_in[CFG_S_LSB +: FIELD_W]);
          ext_mask  <= onehot(la2_data_in[CFG_EXT_LSB +: FIELD_W]);
          ext_en    <= la2_data_in[CFG_EXT_EN];
        end
      end
      if (clr_cnt) begin
        cycle_cnt  <= '0;
        toggle_cnt <= '0;
        done       <= 1'b0;
        chain_out  <= 1'b0;
      end else if (run && !done) begin
        a_input    <= a_next;
        chain_out  <= fb;
        toggle_cnt <= toggle_cnt + LA_W'(fb != chain_out);
        cycle_cnt  <= cnt_next;
        if ((la3_data_in != '0) && (LA_W'(cnt_next) == la3_data_in)) done <= 1'b1;
      end
    end
  end

`ifdef ADDER_RIPPLE_REF_EN
  logic [WIDTH:0] ref_q;

  // Reference lines up with sum_q/carry_q: both register the same operands on the same edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ref_q    <= '0;
      mismatch <= 1'b0;
    end else begin
      ref_q <= {1'b0, a_input} + {1'b0, b_input};
      if (clr_cnt) mismatch <= 1'b0;
      else if (ref_q != {carry_q, sum_q}) mismatch <= 1'b1;
    end
  end
`else
  assign mismatch = 1'b0;
`endif

  assign la1_data_out = active ? sum_q : '0;
  assign la2_data_out = active ? toggle_cnt : '0;
  assign la3_data_out = active ? {done, carry_q, mismatch, cycle_cnt} : '0;
  assign io_out       = active ? (IO_W'(chain_out) << IO_CHAIN_BIT) : '0;
  assign io_oeb       = active ? '0 : '1;

endmodule

// File: tb/tb_instrumented_adder_kogge_wrapper.sv
// Directed bench for the instrumented KS adder wrapper: adder vectors plus ring-mode sequences.
module tb_instrumented_adder_kogge_wrapper;

  localparam logic [31:0] LOAD_A = 32'h1;
  localparam logic [31:0] LOAD_B = 32'h2;
  localparam logic [31:0] LOAD_C = 32'h4;
  localparam logic [31:0] RUN    = 32'h8;
  localparam logic [31:0] CLR    = 32'h10;

  logic        clk, rst, active;
  logic [31:0] la1_in, la2_in, la3_in;
  logic [31:0] la1_out, la2_out, la3_out;
  logic [37:0] io_in, io_out, io_oeb;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        carry;
  } add_vec_t;

  add_vec_t vecs [8];

  instrumented_adder_kogge_wrapper dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .active       (active),
    .la1_data_in  (la1_in),
    .la1_data_out (la1_out),
    .la1_oenb     (32'hFFFF_FFFF),
    .la2_data_in  (la2_in),
    .la2_data_out (la2_out),
    .la2_oenb     (32'hFFFF_FFFF),
    .la3_data_in  (la3_in),
    .la3_data_out (la3_out),
    .la3_oenb     (32'hFFFF_FFFF),
    .io_in        (io_in),
    .io_out       (io_out),
    .io_oeb       (io_oeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Run until done or a cycle budget expires; n returns the cycles taken.
  task automatic run_to_done();
    n = 0;
    while (la3_out[31] !== 1'b1 && n < 20) begin
      step();
      n++;
      if (n <= 2) check("chain_early", 64'(io_out), (n == 2) ? 64'h100 : 64'h0);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
    vecs[6] = '{32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0};
    vecs[7] = '{32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0};

    rst = 1'b1; active = 1'b1; la1_in = '0; la2_in = '0; la3_in = '0; io_in = '0;
    step(); step();
    check("rst_la1", 64'(la1_out), 64'h0);
    check("rst_la2", 64'(la2_out), 64'h0);
    check("rst_la3", 64'(la3_out), 64'h0);
    check("rst_io_out", 64'(io_out), 64'h0);
    check("rst_io_oeb", 64'(io_oeb), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      la2_in = vecs[i].a; la1_in = LOAD_A; step();
      la2_in = vecs[i].b; la1_in = LOAD_B; step();
      la1_in = '0; step();
      check("add_sum", 64'(la1_out), 64'(vecs[i].sum));
      check("add_carry", 64'(la3_out[30]), 64'(vecs[i].carry));
    end

    // Ring on bit 0 feeding itself: oscillates, limit 10.
    la2_in = '0; la1_in = LOAD_A | LOAD_B | LOAD_C | CLR; step();
    la3_in = 32'd10; la1_in = RUN;
    run_to_done();
    check("ring_cycles", 64'(n), 64'd10);
    check("ring_toggles", 64'(la2_out), 64'd9);
    check("ring_la3", 64'(la3_out), 64'h8000_000A);
    check("ring_chain", 64'(io_out), 64'h100);
    repeat (3) step();
    check("ring_hold_la2", 64'(la2_out), 64'd9);
    check("ring_hold_la3", 64'(la3_out), 64'h8000_000A);

    // External bit 0 overrides ring bit 0 with constant 0: no toggles.
    la2_in = 32'h0000_8000; la1_in = LOAD_C | CLR; step();
    la1_in = RUN;
    n = 0;
    while (la3_out[31] !== 1'b1 && n < 20) begin step(); n++; end
    check("ext_cycles", 64'(n), 64'd10);
    check("ext_toggles", 64'(la2_out), 64'd0);
    check("ext_chain", 64'(io_out), 64'h0);
    check("ext_la3", 64'(la3_out), 64'h8000_000A);

    // Inactive: outputs gated while state keeps running.
    active = 1'b0; la2_in = '0; la1_in = LOAD_C | CLR; step();
    la1_in = RUN;
    repeat (12) step();
    check("inact_la1", 64'(la1_out), 64'h0);
    check("inact_la2", 64'(la2_out), 64'h0);
    check("inact_la3", 64'(la3_out), 64'h0);
    check("inact_io_out", 64'(io_out), 64'h0);
    check("inact_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    la1_in = '0; active = 1'b1; step();
    check("react_la2", 64'(la2_out), 64'd9);
    check("react_la3", 64'(la3_out), 64'h8000_000A);
    check("react_io_oeb", 64'(io_oeb), 64'h0);

    // Free-run, then reset mid-run.
    la3_in = '0; la2_in = '0; la1_in = LOAD_C | CLR; step();
    la1_in = RUN;
    repeat (5) step();
    check("free_la2", 64'(la2_out), 64'd4);
    check("free_la3", 64'(la3_out), 64'd5);
    rst = 1'b1; step();
    check("midrst_la1", 64'(la1_out), 64'h0);
    check("midrst_la2", 64'(la2_out), 64'h0);
    check("midrst_la3", 64'(la3_out), 64'h0);
    check("midrst_io_out", 64'(io_out), 64'h0);
    rst = 1'b0;

    // clr_cnt mid-run, loads ignored while running, then a short limit.
    la2_in = '0; la1_in = LOAD_C; step();
    la1_in = RUN;
    repeat (6) step();
    check("run6_la3", 64'(la3_out), 64'd6);
    check("run6_la2", 64'(la2_out), 64'd5);
    la2_in = 32'h0000_0100; la1_in = RUN | CLR | LOAD_B; step();
    check("clr_la2", 64'(la2_out), 64'h0);
    check("clr_la3", 64'(la3_out), 64'h0);
    check("clr_io_out", 64'(io_out), 64'h0);
    la3_in = 32'd3; la1_in = RUN;
    repeat (3) step();
    check("lim3_la3", 64'(la3_out), 64'h8000_0003);
    la1_in = '0; step(); step();
    check("load_ignored", 64'(la1_out & 32'hFFFF_FFFE), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
